// File: rtl/sect571r1_pkg.sv
// sect571r1_pkg: field width, reduction polynomial, curve constants and FSM state shared by sect571r1 blocks.
package sect571r1_pkg;
    localparam int M = 571;
    typedef logic [M-1:0] gf_t;
    // low terms of f = z^571 + z^10 + z^5 + z^2 + 1; the z^571 term is implied by the shift-out bit
    localparam gf_t F_POLY = 571'h425;
    localparam gf_t B  = 571'h2F40E7E_2221F295_DE297117_B7F3D62F_5C6A97FF_CB8CEFF1_CD6BA8CE_4A9A18AD_84FFABBD_8EFA5933_2BE7AD67_56A66E29_4AFD185A_78FF12AA_520E4DE7_39BACA0C_7FFEFF7F_2955727A;
    localparam gf_t GX = 571'h303001D_34B85629_6C16C0D4_0D3CD775_0A93D1D2_955FA80A_A5F40FC8_DB7B2ABD_BDE53950_F4C0D293_CDD711A3_5B67FB14_99AE6003_8614F139_4ABFA3B4_C850D927_E1E7769C_8EEC2D19;
    localparam gf_t GY = 571'h37BF273_42DA639B_6DCCFFFE_B73D69D7_8C6C27A6_009CBBCA_1980F853_3921E8A6_84423E43_BAB08A57_6291AF8F_461BB2A8_B3531D2F_0485C19B_16E2F151_6E23DD3C_1A4827AF_1B8AC15B;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;
    function automatic gf_t gf_mulx(input gf_t v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? F_POLY : '0);
    endfunction
endpackage

// File: rtl/gf2m571_mul_serial.sv
// gf2m571_mul_serial: MSB-first bit-serial GF(2^571) multiplier, one bit of b per cycle, 571 cycles per product.
module gf2m571_mul_serial
    import sect571r1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic start,
    input  gf_t  a,
    input  gf_t  b,
    output logic done,
    output gf_t  p
);
    gf_t        a_q, b_q, acc_q;
    logic [9:0] cnt_q;
    logic       run_q;
    // p is the value acc takes on this edge; with done high it is the finished product
    assign p    = gf_mulx(acc_q) ^ (b_q[cnt_q] ? a_q : '0);
    assign done = run_q && (cnt_q == 10'd0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (clr) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= 10'(M - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= p;
            cnt_q <= cnt_q - 10'd1;
            run_q <= (cnt_q != 10'd0);
        end
    end
endmodule

// File: rtl/sect571r1_pt_chk.sv
// sect571r1_pt_chk: checks y^2 + xy = x^3 + x^2 + b for an affine sect571r1 point using one serial multiplier.
// Optional macro SECT571R1_PT_CHK_INF_EN: (0,0) is reported valid as the point at infinity.
module sect571r1_pt_chk
    import sect571r1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic start,
    input  gf_t  x,
    input  gf_t  y,
    output logic busy,
    output logic done,
    output logic valid
);
    state_t     state_q, state_d;
    gf_t        x_q, y_q, t1_q, t2_q, t3_q, t4_q;
    gf_t        mul_a, mul_b, mul_p, r;
    logic [1:0] k_q, nk;
    logic       ld_q, done_q, valid_q, valid_d, mul_start, mul_done, accept;
`ifdef SECT571R1_PT_CHK_INF_EN
    logic       inf_q;
`endif

    gf2m571_mul_serial u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= S_IDLE;
        else if (clr) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == S_IDLE && start)                      ? S_MUL  :
                  (state_q == S_MUL && mul_done && k_q == 2'd3)      ? S_FIN  :
                  (state_q == S_FIN)                                 ? S_IDLE : state_q;
    end

    // next op index: 0 in the load cycle, otherwise the op after the one finishing now
    always_comb begin
        accept    = (state_q == S_IDLE) && start;
        busy      = (state_q != S_IDLE);
        nk        = ld_q ? 2'd0 : k_q + 2'd1;
        mul_start = (state_q == S_MUL) && (ld_q || (mul_done && k_q != 2'd3));
        mul_a     = (nk == 2'd0) ? y_q : (nk == 2'd3) ? mul_p : x_q;
        mul_b     = (nk < 2'd2) ? y_q : x_q;
        r         = t1_q ^ t2_q ^ t4_q ^ t3_q ^ B;
`ifdef SECT571R1_PT_CHK_INF_EN
        valid_d   = (r == '0) || inf_q;
`else
        valid_d   = (r == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            x_q     <= '0;
            y_q     <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            t4_q    <= '0;
            k_q     <= '0;
            ld_q    <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SECT571R1_PT_CHK_INF_EN
            inf_q   <= 1'b0;
`endif
        end else begin
            ld_q   <= accept;
            done_q <= (state_q == S_FIN);
            if (accept) begin
                x_q     <= x;
                y_q     <= y;
                k_q     <= '0;
                valid_q <= 1'b0;
`ifdef SECT571R1_PT_CHK_INF_EN
                inf_q   <= (x == '0) && (y == '0);
`endif
            end
            if (state_q == S_MUL && mul_done) begin
                k_q  <= k_q + 2'd1;
                t1_q <= (k_q == 2'd0) ? mul_p : t1_q;
                t2_q <= (k_q == 2'd1) ? mul_p : t2_q;
                t3_q <= (k_q == 2'd2) ? mul_p : t3_q;
                t4_q <= (k_q == 2'd3) ? mul_p : t4_q;
            end
            if (state_q == S_FIN) valid_q <= valid_d;
        end
    end

    assign done  = done_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_sect571r1_pt_chk.sv
// tb_sect571r1_pt_chk: directed checks of the sect571r1 point checker, including group-law derived points.
module tb_sect571r1_pt_chk;
    import sect571r1_pkg::*;

    localparam int LAT = 2286;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, start = 1'b0;
    gf_t  x = '0, y = '0;
    logic busy, done, valid;
    int   passed = 0, total = 0;
    gf_t  px [6];
    gf_t  py [6];

    sect571r1_pt_chk dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
        .x(x), .y(y), .busy(busy), .done(done), .valid(valid)
    );

    always #5 clk = ~clk;

    // LSB-first shift-and-add product, independent of the design's MSB-first datapath
    function automatic gf_t fmul(input gf_t a_in, input gf_t b_in);
        gf_t a = a_in, res = '0;
        for (int i = 0; i < M; i++) begin
            if (b_in[i]) res = res ^ a;
            a = {a[M-2:0], 1'b0} ^ (a[M-1] ? gf_t'(571'h425) : gf_t'(0));
        end
        return res;
    endfunction

    // a^(2^571-2) = prod_{i=1..570} a^(2^i)
    function automatic gf_t finv(input gf_t a);
        gf_t s = a, res = gf_t'(1);
        for (int i = 1; i < M; i++) begin
            s = fmul(s, s);
            res = fmul(res, s);
        end
        return res;
    endfunction

    task automatic pt_add(input gf_t x1, y1, x2, y2, output gf_t x3, y3);
        gf_t l;
        l  = fmul(y1 ^ y2, finv(x1 ^ x2));
        x3 = fmul(l, l) ^ l ^ x1 ^ x2 ^ gf_t'(1);
        y3 = fmul(l, x1 ^ x3) ^ x3 ^ y1;
    endtask

    task automatic pt_dbl(input gf_t x1, y1, output gf_t x3, y3);
        gf_t l;
        l  = x1 ^ fmul(y1, finv(x1));
        x3 = fmul(l, l) ^ l ^ gf_t'(1);
        y3 = fmul(x1, x1) ^ fmul(l ^ gf_t'(1), x3);
    endtask

    // Caller is #1 after an edge; start is sampled on the next edge, latency counted from it
    task automatic run_pt(input gf_t ax, ay, output int lat, output logic v);
        x = ax;
        y = ay;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 2400; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        v = valid;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, valid} !== 3'b000) $display("FAIL reset_outputs: got %b want 000", {busy, done, valid});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, valid} !== 3'b000) $display("FAIL after_reset_idle: got %b want 000", {busy, done, valid});
        else passed++;
    endtask

    task automatic test_generator();
        int lat;
        logic v;
        run_pt(GX, GY, lat, v);
        total++;
        if (lat !== LAT) $display("FAIL gen_latency: got %0d want %0d", lat, LAT);
        else passed++;
        total++;
        if (v !== 1'b1) $display("FAIL gen_valid: got %b want 1", v);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL gen_busy_after: got %b want 0", busy);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) $display("FAIL gen_done_one_cycle: got %b want 0", done);
        else passed++;
        total++;
        if (valid !== 1'b1) $display("FAIL gen_valid_held: got %b want 1", valid);
        else passed++;
    endtask

    task automatic test_bad_point();
        int lat;
        logic v;
        run_pt(GX, GY ^ gf_t'(1), lat, v);
        total++;
        if (lat !== LAT) $display("FAIL bad_latency: got %0d want %0d", lat, LAT);
        else passed++;
        total++;
        if (v !== 1'b0) $display("FAIL bad_valid: got %b want 0", v);
        else passed++;
    endtask

    task automatic test_zero();
        int lat;
        logic v, exp_v;
`ifdef SECT571R1_PT_CHK_INF_EN
        exp_v = 1'b1;
`else
        exp_v = 1'b0;
`endif
        run_pt('0, '0, lat, v);
        total++;
        if (lat !== LAT) $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
        else passed++;
        total++;
        if (v !== exp_v) $display("FAIL zero_valid: got %b want %b", v, exp_v);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int lat = 0, nd = 0;
        x = GX;
        y = GY;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 2600; n++) begin
            if (n == 100) begin
                start = 1'b1;
                x = '0;
                y = '0;
            end else start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                lat = n;
            end
        end
        total++;
        if (nd !== 1) $display("FAIL ignore_done_count: got %0d want 1", nd);
        else passed++;
        total++;
        if (lat !== LAT) $display("FAIL ignore_latency: got %0d want %0d", lat, LAT);
        else passed++;
        total++;
        if (valid !== 1'b1) $display("FAIL ignore_valid: got %b want 1", valid);
        else passed++;
    endtask

    task automatic test_clr();
        int nd = 0, lat;
        logic v;
        x = GX;
        y = GY;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            clr = (n == 1000);
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        clr = 1'b0;
        total++;
        if (nd !== 0) $display("FAIL clr_no_done: got %0d want 0", nd);
        else passed++;
        total++;
        if ({busy, valid} !== 2'b00) $display("FAIL clr_outputs: got busy,valid=%b want 00", {busy, valid});
        else passed++;
        run_pt(GX, GY, lat, v);
        total++;
        if (lat !== LAT || v !== 1'b1) $display("FAIL clr_then_gen: got lat=%0d valid=%b want lat=%0d valid=1", lat, v, LAT);
        else passed++;
    endtask

    task automatic build_points();
        pt_dbl(GX, GY, px[0], py[0]);
        pt_add(px[0], py[0], GX, GY, px[1], py[1]);
        pt_dbl(px[0], py[0], px[2], py[2]);
        pt_add(px[2], py[2], GX, GY, px[3], py[3]);
        px[4] = GX;
        py[4] = GX ^ GY;
        px[5] = px[1];
        py[5] = px[1] ^ py[1];
    endtask

    task automatic test_back_to_back();
        int lat;
        logic v;
        for (int i = 0; i < 6; i++) begin
            run_pt(px[i], py[i], lat, v);
            total++;
            if (lat !== LAT || v !== 1'b1) $display("FAIL b2b_on_curve[%0d]: got lat=%0d valid=%b want lat=%0d valid=1", i, lat, v, LAT);
            else passed++;
        end
        for (int i = 0; i < 6; i++) begin
            run_pt(px[i], py[i] ^ {1'b1, 570'b0}, lat, v);
            total++;
            if (lat !== LAT || v !== 1'b0) $display("FAIL b2b_flipped[%0d]: got lat=%0d valid=%b want lat=%0d valid=0", i, lat, v, LAT);
            else passed++;
        end
    endtask

    initial begin
        build_points();
        test_reset();
        test_generator();
        test_bad_point();
        test_zero();
        test_start_ignored();
        test_clr();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
